// File: rtl/uart_rx_scheduler_pkg.sv
// Shared types and helpers for the UART receive scheduler: FSM state encoding,
// default byte width and a constant-safe log2 used to size pointers and counters.
package uart_sched_pkg;

    localparam int DATA_W_DEF = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        INT  = 2'd1,
        WAIT = 2'd2
    } state_t;

    // Smallest r with 2**r >= v.
    function automatic int clog2(input int v);
        int r;
        r = 0;
        while ((1 << r) < v) r++;
        return r;
    endfunction

endpackage

// File: rtl/uart_rx_scheduler_if.sv
// Bundle of receiver-side and CPU-side signals of the scheduler; slave is the
// scheduler's view, master is the view of whatever drives it.
interface uart_rx_scheduler_if
    import uart_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4
) ();
    localparam int PW = clog2(DEPTH) + 1;

    logic              rx_valid;
    logic [DATA_W-1:0] rx_data;
    logic              rx_frame_err;
    logic [DATA_W-1:0] uart_to_cpu_buf;
    logic              read_int;
    logic              cpu_end_read;
    logic              overrun;
    logic              overrun_clr;
    logic [7:0]        frame_err_cnt;
    logic [PW-1:0]     fifo_level;

    modport slave (
        input  rx_valid, rx_data, rx_frame_err, cpu_end_read, overrun_clr,
        output uart_to_cpu_buf, read_int, overrun, frame_err_cnt, fifo_level
    );

    modport master (
        output rx_valid, rx_data, rx_frame_err, cpu_end_read, overrun_clr,
        input  uart_to_cpu_buf, read_int, overrun, frame_err_cnt, fifo_level
    );

endinterface

// File: rtl/uart_rx_scheduler_fifo.sv
// Small byte FIFO with one extra pointer bit for full/empty disambiguation.
// The caller is responsible for never pushing when full without a pop.
module uart_byte_fifo
    import uart_sched_pkg::*;
#(
    parameter int DATA_W = DATA_W_DEF,
    parameter int DEPTH  = 4,
    localparam int AW    = clog2(DEPTH),
    localparam int PW    = AW + 1
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              push,
    input  logic [DATA_W-1:0] push_data,
    input  logic              pop,
    output logic [DATA_W-1:0] head,
    output logic              empty,
    output logic              full,
    output logic [PW-1:0]     level
);

    logic [DATA_W-1:0] mem_q [DEPTH];
    logic [PW-1:0]     wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]     rd_ptr_q, rd_ptr_d;

    // Storage needs no reset: nothing is read before it has been written.
    for (genvar gi = 0; gi < DEPTH; gi++) begin : g_mem
        always_ff @(posedge clk) begin
            if (push && (wr_ptr_q[AW-1:0] == AW'(gi)))
                mem_q[gi] <= push_data;
        end
    end

    always_comb begin
        wr_ptr_d = wr_ptr_q + PW'(push);
        rd_ptr_d = rd_ptr_q + PW'(pop);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    assign head  = mem_q[rd_ptr_q[AW-1:0]];
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign full  = (wr_ptr_q[AW] != rd_ptr_q[AW]) &&
                   (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]);
    assign level = wr_ptr_q - rd_ptr_q;

endmodule

// File: rtl/uart_rx_scheduler.sv
// Buffers received bytes and hands them to the CPU one at a time with an
// interrupt, waiting for an acknowledge edge and re-raising the interrupt on timeout.
module uart_rx_scheduler
    import uart_sched_pkg::*;
#(
    parameter int DATA_W  = DATA_W_DEF,
    parameter int DEPTH   = 4,
    parameter int INT_LEN = 2,
    parameter int TIMEOUT = 1024
) (
    input  logic                 clk,
    input  logic                 rst_n,
    uart_rx_scheduler_if.slave   bus
);

    localparam int IW = clog2(INT_LEN + 1);
    localparam int TW = (TIMEOUT > 0) ? clog2(TIMEOUT + 1) : 1;

    logic              end_read_q;
    logic              overrun_q, overrun_d;
    logic [7:0]        fec_q, fec_d;
    state_t            state_q;
    logic [DATA_W-1:0] buf_q;
    logic              read_int_q;
    logic [IW-1:0]     icnt_q;
    logic [TW-1:0]     tcnt_q;

    logic              ack, rx_ok, push, pop, ovr_set;
    logic              empty, full;
    logic [DATA_W-1:0] head;

    uart_byte_fifo #(.DATA_W(DATA_W), .DEPTH(DEPTH)) u_fifo (
        .clk       (clk),
        .rst_n     (rst_n),
        .push      (push),
        .push_data (bus.rx_data),
        .pop       (pop),
        .head      (head),
        .empty     (empty),
        .full      (full),
        .level     (bus.fifo_level)
    );

    // A full FIFO still accepts a byte when the head leaves in the same cycle.
    always_comb begin
        ack     = bus.cpu_end_read & ~end_read_q;
        rx_ok   = bus.rx_valid & ~bus.rx_frame_err;
        pop     = (state_q == IDLE) & ~empty;
        push    = rx_ok & (~full | pop);
        ovr_set = rx_ok & full & ~pop;

        overrun_d = overrun_q;
        if (ovr_set)
            overrun_d = 1'b1;
        else if (bus.overrun_clr)
            overrun_d = 1'b0;

        fec_d = fec_q;
        if (bus.rx_valid && bus.rx_frame_err && (fec_q != 8'hFF))
            fec_d = fec_q + 8'd1;
    end

    // end_read_q resets high so an acknowledge line already high is not an edge.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            end_read_q <= 1'b1;
            overrun_q  <= 1'b0;
            fec_q      <= '0;
        end else begin
            end_read_q <= bus.cpu_end_read;
            overrun_q  <= overrun_d;
            fec_q      <= fec_d;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q    <= IDLE;
            buf_q      <= '0;
            read_int_q <= 1'b0;
            icnt_q     <= '0;
            tcnt_q     <= '0;
        end else begin
            case (state_q)
                IDLE: begin
                    if (!empty) begin
                        buf_q      <= head;
                        read_int_q <= 1'b1;
                        icnt_q     <= IW'(INT_LEN - 1);
                        state_q    <= INT;
                    end
                end
                INT: begin
                    if (ack) begin
                        read_int_q <= 1'b0;
                        state_q    <= IDLE;
                    end else if (icnt_q == '0) begin
                        read_int_q <= 1'b0;
                        tcnt_q     <= '0;
                        state_q    <= WAIT;
                    end else begin
                        icnt_q <= icnt_q - IW'(1);
                    end
                end
                WAIT: begin
                    if (ack) begin
                        state_q <= IDLE;
                    end else if ((TIMEOUT != 0) && (tcnt_q == TW'(TIMEOUT - 1))) begin
                        // Re-issue for the byte already in buf_q; the FIFO is untouched.
                        read_int_q <= 1'b1;
                        icnt_q     <= IW'(INT_LEN - 1);
                        state_q    <= INT;
                    end else begin
                        tcnt_q <= tcnt_q + TW'(1);
                    end
                end
                default: state_q <= IDLE;
            endcase
        end
    end

    assign bus.uart_to_cpu_buf = buf_q;
    assign bus.read_int        = read_int_q;
    assign bus.overrun         = overrun_q;
    assign bus.frame_err_cnt   = fec_q;

endmodule

// File: tb/tb_uart_rx_scheduler.sv
// Directed bench for uart_rx_scheduler with DEPTH=4, INT_LEN=2, TIMEOUT=16.
// Inputs are driven and outputs sampled just after the falling clock edge.
module tb_uart_rx_scheduler;

    localparam int DW      = 8;
    localparam int DEPTH   = 4;
    localparam int INT_LEN = 2;
    localparam int TIMEOUT = 16;

    logic clk = 1'b0;
    logic rst_n;
    int   n_checks = 0;
    int   n_fail   = 0;

    always #5 clk = ~clk;

    uart_rx_scheduler_if #(.DATA_W(DW), .DEPTH(DEPTH)) bus ();

    uart_rx_scheduler #(
        .DATA_W (DW),
        .DEPTH  (DEPTH),
        .INT_LEN(INT_LEN),
        .TIMEOUT(TIMEOUT)
    ) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus.slave)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", tag, got, exp, $time);
        end else begin
            $display("ok   %s: 0x%0h", tag, got);
        end
    endtask

    task automatic cycle();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic send(input logic [7:0] d);
        bus.rx_valid = 1'b1;
        bus.rx_data  = d;
        cycle();
        bus.rx_valid = 1'b0;
    endtask

    task automatic pulse_ack();
        bus.cpu_end_read = 1'b1;
        cycle();
        bus.cpu_end_read = 1'b0;
        cycle();
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog expired");
    end

    initial begin
        logic [7:0] exp_b;

        rst_n            = 1'b0;
        bus.rx_valid     = 1'b0;
        bus.rx_data      = '0;
        bus.rx_frame_err = 1'b0;
        bus.cpu_end_read = 1'b1;
        bus.overrun_clr  = 1'b0;
        cycle(); cycle(); cycle();
        check("rst_buf",      32'(bus.uart_to_cpu_buf), 32'h0);
        check("rst_read_int", 32'(bus.read_int),        32'h0);
        check("rst_overrun",  32'(bus.overrun),         32'h0);
        check("rst_fec",      32'(bus.frame_err_cnt),   32'h0);
        check("rst_level",    32'(bus.fifo_level),      32'h0);

        // T1: single byte, acknowledge line held high since reset
        rst_n = 1'b1;
        send(8'hA5);
        check("t1_level_push", 32'(bus.fifo_level), 32'd1);
        check("t1_int_push",   32'(bus.read_int),   32'd0);
        cycle();
        check("t1_buf",        32'(bus.uart_to_cpu_buf), 32'hA5);
        check("t1_int_c1",     32'(bus.read_int),   32'd1);
        check("t1_level_pop",  32'(bus.fifo_level), 32'd0);
        cycle();
        check("t1_int_c2",     32'(bus.read_int),   32'd1);
        cycle();
        check("t1_int_c3",     32'(bus.read_int),   32'd0);
        bus.cpu_end_read = 1'b0;
        cycle();
        pulse_ack();
        check("t1_int_after_ack", 32'(bus.read_int), 32'd0);
        check("t1_buf_hold",      32'(bus.uart_to_cpu_buf), 32'hA5);

        // T2: burst without ack, overrun, ordered delivery
        for (int i = 1; i <= 5; i++) send(8'(i));
        check("t2_level4",    32'(bus.fifo_level), 32'd4);
        check("t2_buf01",     32'(bus.uart_to_cpu_buf), 32'h01);
        check("t2_no_ovr",    32'(bus.overrun), 32'd0);
        send(8'h06);
        check("t2_overrun",   32'(bus.overrun), 32'd1);
        check("t2_level_full", 32'(bus.fifo_level), 32'd4);
        for (int i = 2; i <= 5; i++) begin
            pulse_ack();
            check($sformatf("t2_buf%0d", i),   32'(bus.uart_to_cpu_buf), 32'(i));
            check($sformatf("t2_int%0d", i),   32'(bus.read_int), 32'd1);
            check($sformatf("t2_level%0d", i), 32'(bus.fifo_level), 32'(5 - i));
        end
        pulse_ack();
        check("t2_int_end", 32'(bus.read_int), 32'd0);

        // T3: frame errors saturate the drop counter
        bus.rx_valid     = 1'b1;
        bus.rx_frame_err = 1'b1;
        bus.rx_data      = 8'h77;
        for (int i = 0; i < 100; i++) cycle();
        check("t3_fec100", 32'(bus.frame_err_cnt), 32'd100);
        for (int i = 0; i < 200; i++) cycle();
        bus.rx_valid     = 1'b0;
        bus.rx_frame_err = 1'b0;
        check("t3_fec_sat",  32'(bus.frame_err_cnt), 32'd255);
        check("t3_level",    32'(bus.fifo_level), 32'd0);
        check("t3_read_int", 32'(bus.read_int), 32'd0);

        // T4: timeout re-issue every TIMEOUT+INT_LEN cycles
        send(8'hC3);
        cycle();
        for (int k = 0; k <= 36; k++) begin
            check($sformatf("t4_int_k%0d", k), 32'(bus.read_int),
                  32'(((k % (TIMEOUT + INT_LEN)) < INT_LEN) ? 1 : 0));
            if (k < 36) cycle();
        end
        check("t4_buf_same", 32'(bus.uart_to_cpu_buf), 32'hC3);
        bus.cpu_end_read = 1'b1;
        cycle();
        check("t4_ack_in_int", 32'(bus.read_int), 32'd0);
        bus.cpu_end_read = 1'b0;
        for (int i = 0; i < 20; i++) cycle();
        check("t4_quiet", 32'(bus.read_int), 32'd0);

        // T5: overrun clear vs set, push with pop when full, async reset in WAIT
        bus.overrun_clr = 1'b1;
        cycle();
        bus.overrun_clr = 1'b0;
        check("t5_ovr_cleared", 32'(bus.overrun), 32'd0);
        for (int i = 0; i < 5; i++) send(8'(8'h10 + i));
        check("t5_level4", 32'(bus.fifo_level), 32'd4);
        bus.overrun_clr = 1'b1;
        send(8'h15);
        bus.overrun_clr = 1'b0;
        check("t5_set_wins", 32'(bus.overrun), 32'd1);
        bus.cpu_end_read = 1'b1;
        cycle();
        bus.cpu_end_read = 1'b0;
        send(8'h16);
        exp_b = 8'h11;
        check("t5_full_pushpop_level", 32'(bus.fifo_level), 32'd4);
        check("t5_full_pushpop_buf",   32'(bus.uart_to_cpu_buf), 32'(exp_b));
        cycle(); cycle();
        pulse_ack();
        cycle(); cycle();
        check("t5_wait_int",   32'(bus.read_int), 32'd0);
        check("t5_wait_level", 32'(bus.fifo_level), 32'd3);
        check("t5_wait_buf",   32'(bus.uart_to_cpu_buf), 32'h12);
        #2 rst_n = 1'b0;
        #1;
        check("t5_arst_buf",  32'(bus.uart_to_cpu_buf), 32'h0);
        check("t5_arst_int",  32'(bus.read_int),        32'h0);
        check("t5_arst_ovr",  32'(bus.overrun),         32'h0);
        check("t5_arst_fec",  32'(bus.frame_err_cnt),   32'h0);
        check("t5_arst_lvl",  32'(bus.fifo_level),      32'h0);
        cycle();
        rst_n = 1'b1;
        cycle();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
